alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4-bit combinational ALU between two requesters.
- It accepts one operation at a time over a valid/ready request port and drives the ALU operand and opcode inputs for one cycle.
- It captures the ALU result and flags, masks any flag that the opcode does not define, and returns a tagged response over a valid/ready response port.
- It sits between the pipeline-side requesters and the shared ALU instance.

Parameters:
- RR_INIT, 1'b1, initial value of last_grant; 1 means port 0 wins the first contention.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  4  operand A
- req0_b  input  4  operand B
- req0_op  input  3  ALU opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as port 0, for requester 1
- alu_a  output  4  ALU operand A
- alu_b  output  4  ALU operand B
- alu_en  output  3  ALU opcode
- alu_ret  input  4  ALU result
- alu_carry  input  1  ALU carry
- alu_zero  input  1  ALU zero
- alu_overflow  input  1  ALU overflow
- alu_less  input  1  ALU less
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  index of the requester that issued the operation
- rsp_ret  output  4  masked result
- rsp_flags  output  4  {carry, zero, overflow, less}, masked

Behaviour:
- Reset: on rst high at a clk edge, all of the following apply next cycle:
  - state returns to IDLE and last_grant is set to RR_INIT.
  - req0_ready, req1_ready and rsp_valid are 0.
  - alu_a, alu_b and alu_en are 0; rsp_id, rsp_ret and rsp_flags are 0.
  - An in-flight operation or pending response is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only for the granted port, only while in IDLE.
  - Grant rule: if exactly one valid, grant it. If both are valid, grant the port that is not last_grant.
  - On a handshake: latch a, b, op and id into alu_a, alu_b, alu_en and an id register; update last_grant to the granted port; go to EXEC.
  - With no valid request: stay in IDLE.
- EXEC (one cycle):
  - The ALU inputs are stable from the registers.
  - At the end of the cycle, capture the masked ALU outputs into the rsp_* registers, set rsp_valid, and go to RESP.
- RESP:
  - Hold rsp_* and rsp_valid until rsp_ready is seen high.
  - On rsp_ready: clear rsp_valid and return to IDLE.
  - Both reqN_ready are low throughout; a new request is not accepted in the same cycle as the response handshake.
- Latency: request handshake at cycle N means rsp_valid is high at cycle N+2. Maximum throughput is one operation per 3 cycles.
- Masking (the ALU leaves undefined outputs stale, so the controller must mask them):
  - Ops 000 and 001: ret, carry, zero and overflow pass through; less = 0.
  - Op 110: ret, carry, overflow and less pass through; zero = 0.
  - Op 111: zero passes through; ret = 0; carry, overflow and less = 0.
  - Ops 010, 011, 100 and 101: ret passes through; all flags = 0.
- alu_a, alu_b and alu_en hold their last value outside EXEC; no operand bubbles are inserted.
- A requester may change or drop its valid while not granted; the block must not require valid to be held.
- Back-to-back requests from the same port are allowed. Fairness comes only from last_grant under contention.

Test Plan:
- Simple add: reset, then req0 op=000 a=7 b=1.
  - Required: rsp_valid at N+2, rsp_id=0, rsp_ret=8, flags carry=0, zero=0, overflow=1, less=0.
- Subtract to zero: req1 op=001 a=3 b=3.
  - Required: rsp_id=1, rsp_ret=0, carry=1, zero=1, overflow=0, less=0.
- Contention: after reset, req0 (op=110 a=4'hE b=1) and req1 (op=111 a=5 b=5) are valid in the same cycle and held.
  - Required: the first response is rsp_id=0 with rsp_ret=4'hD, less=1, carry=1, zero=0.
  - Required: the second response is rsp_id=1 with rsp_ret=0, zero=1, other flags 0.
  - Grants then alternate 0, 1, 0, 1 while both stay valid.
- Backpressure: hold rsp_ready low for 3 cycles while a response is pending, with req0 valid.
  - Required: rsp_* stay stable and req0_ready stays 0.
  - Raise rsp_ready: the response is accepted, and req0_ready is asserted the following cycle.
- Logic op mask: req0 op=101 a=4'hC b=4'hA.
  - Required: rsp_ret=4'h6 and rsp_flags=4'b0000, even though the previous op left the ALU zero output at 1.
- Reset mid-operation: assert rst during EXEC, and separately during RESP.
  - Required: rsp_valid=0 and all outputs 0 the next cycle; no stale response afterwards; the next grant follows RR_INIT.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one 4-bit ALU between two requesters.
// Ports: clk/rst; req0_*/req1_* valid/ready request ports (a, b, op);
//        alu_a/alu_b/alu_en drive the shared ALU, alu_ret/alu_carry/alu_zero/alu_overflow/alu_less return from it;
//        rsp_valid/rsp_ready response port carrying rsp_id, masked rsp_ret and rsp_flags {carry, zero, overflow, less}.
module alu_arbiter #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_en,
  input  logic [3:0] alu_ret,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_less,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_ret,
  output logic [3:0] rsp_flags
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state_q, state_d;
  logic       last_q, id_q, gnt, hs;
  logic [3:0] a_q, b_q, m_ret, m_flags, rsp_ret_q, rsp_flags_q;
  logic [2:0] op_q;
  logic       rsp_valid_q, rsp_id_q;
  // port 1 wins when it is the only requester, or when port 0 was granted last
  assign gnt        = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = (state_q == IDLE) & req0_valid & ~gnt;
  assign req1_ready = (state_q == IDLE) & gnt;
  assign hs         = req0_ready | req1_ready;
  // the ALU leaves undefined outputs stale, so only the opcode's defined outputs pass
  always_comb begin
    m_ret   = (op_q == 3'b111) ? 4'd0 : alu_ret;
    m_flags = (op_q[2:1] == 2'b00) ? {alu_carry, alu_zero, alu_overflow, 1'b0} :
              (op_q == 3'b110)     ? {alu_carry, 1'b0, alu_overflow, alu_less} :
              (op_q == 3'b111)     ? {1'b0, alu_zero, 2'b00} : 4'd0;
    state_d = (state_q == IDLE) ? (hs ? EXEC : IDLE) :
              (state_q == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= RR_INIT;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_ret_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_q <= gnt;
        id_q   <= gnt;
        a_q    <= gnt ? req1_a : req0_a;
        b_q    <= gnt ? req1_b : req0_b;
        op_q   <= gnt ? req1_op : req0_op;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_ret_q   <= m_ret;
        rsp_flags_q <= m_flags;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_en    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ret   = rsp_ret_q;
  assign rsp_flags = rsp_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU that drives junk on undefined outputs.
module tb_alu_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0_valid = 1'b0, req0_ready;
  logic [3:0] req0_a = '0, req0_b = '0;
  logic [2:0] req0_op = '0;
  logic       req1_valid = 1'b0, req1_ready;
  logic [3:0] req1_a = '0, req1_b = '0;
  logic [2:0] req1_op = '0;
  logic [3:0] alu_a, alu_b, alu_ret;
  logic [2:0] alu_en;
  logic       alu_carry, alu_zero, alu_overflow, alu_less;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [3:0] rsp_ret, rsp_flags;
  int         n_vec = 0, n_err = 0, cyc = 0;
  logic [8:0] sb[$];
  int         lat[$];
  logic [8:0] e;
  logic       prev_v = 1'b0;
  logic [12:0] snap;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
    .alu_ret(alu_ret), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_less(alu_less),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ret(rsp_ret), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared ALU: undefined outputs are left at junk values so masking is exercised
  logic [4:0] s_add, s_sub;
  always_comb begin
    s_add = {1'b0, alu_a} + {1'b0, alu_b};
    s_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
    alu_ret = 4'hA; alu_carry = 1'b1; alu_zero = 1'b1; alu_overflow = 1'b1; alu_less = 1'b1;
    case (alu_en)
      3'd0: begin
        alu_ret = s_add[3:0]; alu_carry = s_add[4]; alu_zero = (s_add[3:0] == 4'd0);
        alu_overflow = (alu_a[3] == alu_b[3]) && (s_add[3] != alu_a[3]);
      end
      3'd1: begin
        alu_ret = s_sub[3:0]; alu_carry = s_sub[4]; alu_zero = (s_sub[3:0] == 4'd0);
        alu_overflow = (alu_a[3] != alu_b[3]) && (s_sub[3] != alu_a[3]);
      end
      3'd6: begin
        alu_ret = s_sub[3:0]; alu_carry = s_sub[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (s_sub[3] != alu_a[3]);
        alu_less = s_sub[3] ^ alu_overflow;
      end
      3'd7: alu_zero = (alu_a == alu_b);
      3'd2: alu_ret = alu_a & alu_b;
      3'd3: alu_ret = alu_a | alu_b;
      3'd4: alu_ret = ~alu_a;
      3'd5: alu_ret = alu_a ^ alu_b;
      default: ;
    endcase
  end

  // expected {ret, carry, zero, overflow, less} from arithmetic semantics, undefined outputs zero
  function automatic logic [7:0] exp_of(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ua = int'(a), ub = int'(b);
    int sa = a[3] ? ua - 16 : ua;
    int sb_ = b[3] ? ub - 16 : ub;
    int r;
    logic [3:0] ret = 4'd0;
    logic c = 1'b0, z = 1'b0, v = 1'b0, l = 1'b0;
    case (op)
      3'd0: begin
        r = ua + ub; ret = r[3:0]; c = r > 15; z = ret == 4'd0;
        v = (sa + sb_ > 7) || (sa + sb_ < -8);
      end
      3'd1, 3'd6: begin
        r = ua - ub + 16; ret = r[3:0]; c = ua >= ub;
        v = (sa - sb_ > 7) || (sa - sb_ < -8);
        if (op == 3'd1) z = ret == 4'd0; else l = sa < sb_;
      end
      3'd7: z = a == b;
      3'd2: ret = a & b;
      3'd3: ret = a | b;
      3'd4: ret = ~a;
      3'd5: ret = a ^ b;
      default: ;
    endcase
    return {ret, c, z, v, l};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      lat.delete();
      prev_v = 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin sb.push_back({1'b0, exp_of(req0_op, req0_a, req0_b)}); lat.push_back(cyc); end
      if (req1_valid && req1_ready) begin sb.push_back({1'b1, exp_of(req1_op, req1_a, req1_b)}); lat.push_back(cyc); end
      if (rsp_valid && !prev_v) begin
        if (lat.size() == 0) check("stale_rsp", 1, 0);
        else check("latency", cyc - lat.pop_front(), 2);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e[8]);
          check("rsp_ret", rsp_ret, e[7:4]);
          check("rsp_flags", rsp_flags, e[3:0]);
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit p, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bit ok = 0;
    if (p) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = p ? req1_ready : req0_ready;
    end
    if (!ok) check("hs_timeout", 0, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && !rsp_valid;
    end
    check("drain", ok, 1);
    tick();
  endtask

  task automatic wait_grant(output bit got_ok);
    got_ok = 0;
    for (int i = 0; i < 30 && !got_ok; i++) begin
      @(negedge clk);
      got_ok = req0_ready | req1_ready;
    end
    if (!got_ok) check("grant_timeout", 0, 1);
  endtask

  task automatic contend(input bit first);
    bit ok;
    req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'd0;
    req1_a = 4'd2; req1_b = 4'd1; req1_op = 3'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grant(ok);
    if (ok) check("rr_first", req1_ready, first);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {req0_ready, req1_ready, rsp_valid, alu_a, alu_b, alu_en, rsp_id, rsp_ret, rsp_flags}, 0);
  endtask

  initial begin
    bit ok;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    tick();
    rst = 1'b0;

    do_req(0, 4'd7, 4'd1, 3'd0);
    drain();
    do_req(1, 4'd3, 4'd3, 3'd1);
    drain();

    rst = 1'b1; tick(); rst = 1'b0;
    req0_a = 4'hE; req0_b = 4'd1; req0_op = 3'd6;
    req1_a = 4'd5; req1_b = 4'd5; req1_op = 3'd7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(ok);
      if (ok) check("rr_alternate", req1_ready, k % 2);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    rsp_ready = 1'b0;
    req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'd0; req0_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    check("bp_rsp_timeout", ok, 1);
    snap = {rsp_valid, rsp_id, rsp_ret, rsp_flags, 3'b000};
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {rsp_valid, rsp_id, rsp_ret, rsp_flags, 3'b000}, snap);
      check("bp_req0_ready", req0_ready, 0);
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("accept_req0_ready", req0_ready, 0);
    tick();
    @(negedge clk);
    check("after_accept_req0_ready", req0_ready, 1);
    check("after_accept_rsp_valid", rsp_valid, 0);
    tick();
    req0_valid = 1'b0;
    drain();

    do_req(0, 4'hC, 4'hA, 3'd5);
    drain();

    do_req(0, 4'd2, 4'd9, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_exec_outputs");
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("rst_exec_no_rsp", rsp_valid, 0);
    contend(0);

    rsp_ready = 1'b0;
    do_req(0, 4'd6, 4'd3, 3'd6);
    tick();
    check("in_resp", rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_resp_outputs");
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    check("rst_resp_no_rsp", rsp_valid, 0);
    contend(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
